// File: rtl/rx_cmd_decode.sv
// rx_cmd_decode: decodes "#<cmd><digit>\r" UART frames into a timed door unlock and an LED latch.
// Define RXCMD_REPLY_EN to enable the 'K'/'E' reply transmitter; otherwise TxD_data/TxD_start stay 0.
module rx_cmd_decode #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int FRAME_TIMEOUT = 5_000_000
) (
  input  logic       FPGA_CLK1_50,
  input  logic       reset,
  input  logic [7:0] RxD_data,
  input  logic       RxD_data_ready,
  input  logic       TxD_busy,
  output logic       unlock_signal,
  output logic [7:0] LED,
  output logic       frame_err,
  output logic [7:0] TxD_data,
  output logic       TxD_start
);

  localparam int TW  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int TOW = $clog2(FRAME_TIMEOUT + 1);

`ifdef RXCMD_REPLY_EN
  localparam logic REPLY_EN = 1'b1;
`else
  localparam logic REPLY_EN = 1'b0;
`endif

  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_U    = 8'h55;
  localparam logic [7:0] CH_L    = 8'h4C;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_K    = 8'h4B;
  localparam logic [7:0] CH_E    = 8'h45;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GOT_START = 2'd1,
    GOT_CMD   = 2'd2,
    GOT_ARG   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             is_u_q, is_u_d;
  logic [7:0]       arg_q, arg_d;
  logic [TOW-1:0]   to_q, to_d;
  logic             err_q, err_d;
  logic             exec_s;
  logic [3:0]       sec_q, sec_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             unlock_q, unlock_d;
  logic [7:0]       led_q, led_d;
  logic             pend_q, pend_d;
  logic [7:0]       pbyte_q, pbyte_d;
  logic [7:0]       txd_q, txd_d;
  logic             txs_q, txs_d;
  logic             issue_s;
  logic             is_digit_s;

  assign is_digit_s = (RxD_data >= 8'h30) && (RxD_data <= 8'h39);

  // Frame FSM and inter-byte timeout; a strobe always beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    is_u_d  = is_u_q;
    arg_d   = arg_q;
    to_d    = to_q;
    err_d   = 1'b0;
    exec_s  = 1'b0;
    if (RxD_data_ready) begin
      to_d = '0;
      if (RxD_data == CH_HASH) begin
        state_d = GOT_START;
        err_d   = (state_q != IDLE);
      end else begin
        case (state_q)
          IDLE: state_d = IDLE;
          GOT_START: begin
            if ((RxD_data == CH_U) || (RxD_data == CH_L)) begin
              is_u_d  = (RxD_data == CH_U);
              state_d = GOT_CMD;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
          GOT_CMD: begin
            if (is_digit_s) begin
              arg_d   = RxD_data;
              state_d = GOT_ARG;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
          GOT_ARG: begin
            state_d = IDLE;
            if (RxD_data == CH_CR) begin
              exec_s = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      if (to_q == TOW'(FRAME_TIMEOUT - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
        to_d    = '0;
      end else begin
        to_d = to_q + {{(TOW-1){1'b0}}, 1'b1};
      end
    end else begin
      to_d = '0;
    end
  end

  // Unlock countdown and LED latch; an executed frame overrides the countdown.
  always_comb begin
    sec_d  = sec_q;
    tick_d = tick_q;
    led_d  = led_q;
    if (sec_q != 4'd0) begin
      if (tick_q == TW'(TICKS_PER_SEC - 1)) begin
        tick_d = '0;
        sec_d  = sec_q - 4'd1;
      end else begin
        tick_d = tick_q + {{(TW-1){1'b0}}, 1'b1};
      end
    end else begin
      tick_d = '0;
    end
    if (exec_s) begin
      if (is_u_q) begin
        sec_d  = arg_q[3:0];
        tick_d = '0;
      end else begin
        led_d = arg_q;
      end
    end else begin
      led_d = led_q;
    end
    unlock_d = (sec_d != 4'd0);
  end

  // Single-entry reply slot; the newest event overwrites an unsent reply.
  always_comb begin
    issue_s = REPLY_EN && pend_q && !TxD_busy;
    txs_d   = issue_s;
    txd_d   = issue_s ? pbyte_q : txd_q;
    if (REPLY_EN && (exec_s || err_d)) begin
      pend_d  = 1'b1;
      pbyte_d = exec_s ? CH_K : CH_E;
    end else begin
      pend_d  = pend_q && !issue_s;
      pbyte_d = pbyte_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge FPGA_CLK1_50) begin
    if (reset) begin
      state_q  <= IDLE;
      is_u_q   <= 1'b0;
      arg_q    <= 8'h00;
      to_q     <= '0;
      err_q    <= 1'b0;
      sec_q    <= 4'd0;
      tick_q   <= '0;
      unlock_q <= 1'b0;
      led_q    <= 8'h00;
      pend_q   <= 1'b0;
      pbyte_q  <= 8'h00;
      txd_q    <= 8'h00;
      txs_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_u_q   <= is_u_d;
      arg_q    <= arg_d;
      to_q     <= to_d;
      err_q    <= err_d;
      sec_q    <= sec_d;
      tick_q   <= tick_d;
      unlock_q <= unlock_d;
      led_q    <= led_d;
      pend_q   <= pend_d;
      pbyte_q  <= pbyte_d;
      txd_q    <= txd_d;
      txs_q    <= txs_d;
    end
  end

  assign unlock_signal = unlock_q;
  assign LED           = led_q;
  assign frame_err     = err_q;
  assign TxD_data      = txd_q;
  assign TxD_start     = txs_q;

endmodule

// File: tb/tb_rx_cmd_decode.sv
// Randomized and directed bench for rx_cmd_decode against a frame-level reference model.
module tb_rx_cmd_decode;
  localparam int TPS = 10;
  localparam int FTO = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       TxD_busy;
  logic       unlock_signal;
  logic [7:0] LED;
  logic       frame_err;
  logic [7:0] TxD_data;
  logic       TxD_start;

  int n_vec = 0;
  int n_err = 0;

  // reference model: collected byte count, idle count, remaining unlock cycles
  int         m_n = 0;
  logic       m_cmd_u = 1'b0;
  logic [7:0] m_arg = 8'h00;
  int         m_idle = 0;
  int         m_rem = 0;
  logic [7:0] m_led = 8'h00;
  logic       m_err = 1'b0;
  logic       m_pend = 1'b0;
  logic [7:0] m_pbyte = 8'h00;
  logic [7:0] m_txd = 8'h00;
  logic       m_txs = 1'b0;

  rx_cmd_decode #(.TICKS_PER_SEC(TPS), .FRAME_TIMEOUT(FTO)) dut (
    .FPGA_CLK1_50  (clk),
    .reset         (reset),
    .RxD_data      (RxD_data),
    .RxD_data_ready(RxD_data_ready),
    .TxD_busy      (TxD_busy),
    .unlock_signal (unlock_signal),
    .LED           (LED),
    .frame_err     (frame_err),
    .TxD_data      (TxD_data),
    .TxD_start     (TxD_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rdy, input logic [7:0] d, input logic busy, input logic rst);
    logic exec;
    int   nrem;
    if (rst) begin
      m_n = 0; m_cmd_u = 1'b0; m_arg = 8'h00; m_idle = 0; m_rem = 0; m_led = 8'h00;
      m_err = 1'b0; m_pend = 1'b0; m_pbyte = 8'h00; m_txd = 8'h00; m_txs = 1'b0;
      return;
    end
    exec  = 1'b0;
    m_err = 1'b0;
    nrem  = (m_rem > 0) ? m_rem - 1 : 0;
    if (rdy) begin
      m_idle = 0;
      if (d == 8'h23) begin
        m_err = (m_n != 0);
        m_n = 1;
      end else if (m_n == 1) begin
        if (d == 8'h55 || d == 8'h4C) begin m_cmd_u = (d == 8'h55); m_n = 2; end
        else begin m_err = 1'b1; m_n = 0; end
      end else if (m_n == 2) begin
        if (d >= 8'h30 && d <= 8'h39) begin m_arg = d; m_n = 3; end
        else begin m_err = 1'b1; m_n = 0; end
      end else if (m_n == 3) begin
        if (d == 8'h0D) exec = 1'b1;
        else m_err = 1'b1;
        m_n = 0;
      end
    end else if (m_n != 0) begin
      m_idle++;
      if (m_idle == FTO) begin m_err = 1'b1; m_n = 0; m_idle = 0; end
    end else begin
      m_idle = 0;
    end
    if (exec) begin
      if (m_cmd_u) nrem = (int'(m_arg) - 48) * TPS;
      else m_led = m_arg;
    end
    m_rem = nrem;
`ifdef RXCMD_REPLY_EN
    m_txs = 1'b0;
    if (m_pend && !busy) begin m_txd = m_pbyte; m_txs = 1'b1; m_pend = 1'b0; end
    if (exec) begin m_pend = 1'b1; m_pbyte = 8'h4B; end
    else if (m_err) begin m_pend = 1'b1; m_pbyte = 8'h45; end
`else
    m_txs = 1'b0;
    m_txd = 8'h00;
`endif
  endtask

  task automatic cycle(input logic rdy, input logic [7:0] d, input logic busy, input logic rst);
    reset = rst; RxD_data = d; RxD_data_ready = rdy; TxD_busy = busy;
    @(posedge clk);
    #1;
    model_step(rdy, d, busy, rst);
    chk("unlock", {31'd0, unlock_signal}, {31'd0, (m_rem > 0)});
    chk("led", {24'd0, LED}, {24'd0, m_led});
    chk("frame_err", {31'd0, frame_err}, {31'd0, m_err});
    chk("txd", {24'd0, TxD_data}, {24'd0, m_txd});
    chk("txs", {31'd0, TxD_start}, {31'd0, m_txs});
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int cnt, errs, errcyc, pulses;
    logic [7:0] fr [4];
    logic [7:0] pick;

    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // U '3': unlock for exactly 3*TPS cycles, no error
    send(8'h23); send(8'h55); send(8'h33); send(8'h0D);
    cnt = unlock_signal ? 1 : 0; errs = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      if (unlock_signal) cnt++;
      if (frame_err) errs++;
    end
    chk("u3_len", cnt, 30);
    chk("u3_noerr", errs, 0);

    // L '7'
    send(8'h23); send(8'h4C); send(8'h37); send(8'h0D);
    chk("l7_led", {24'd0, LED}, 32'h37);
    chk("l7_unlock", {31'd0, unlock_signal}, 32'd0);
    idle(3);

    // bad command, then recovery
    send(8'h23); send(8'h58);
    chk("badcmd_err", {31'd0, frame_err}, 32'd1);
    send(8'h23); send(8'h4C); send(8'h31); send(8'h0D);
    chk("l1_led", {24'd0, LED}, 32'h31);
    idle(2);

    // timeout after command byte
    send(8'h23); send(8'h55);
    errcyc = -1;
    for (int i = 1; i <= 25; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      if (frame_err && errcyc < 0) errcyc = i;
    end
    chk("to_cycle", errcyc, 20);
    send(8'h55);
    chk("to_ignored", {31'd0, frame_err}, 32'd0);
    idle(2);

    // U '5' then cancel with U '0'
    send(8'h23); send(8'h55); send(8'h35); send(8'h0D);
    idle(12);
    send(8'h23); send(8'h55); send(8'h30); send(8'h0D);
    chk("cancel", {31'd0, unlock_signal}, 32'd0);
    idle(2);

    // reset during U '9'
    send(8'h23); send(8'h55); send(8'h39); send(8'h0D);
    idle(5);
    chk("u9_on", {31'd0, unlock_signal}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_unlock", {31'd0, unlock_signal}, 32'd0);
    chk("rst_noerr", {31'd0, frame_err}, 32'd0);
    idle(2);

    // reply held off by busy transmitter
    send(8'h23); send(8'h4C); send(8'h32); send(8'h0D);
    pulses = 0;
    for (int i = 1; i <= 15; i++) begin
      cycle(1'b0, 8'h00, (i <= 8), 1'b0);
      if (TxD_start) begin
        pulses++;
        chk("reply_cyc", i, 9);
        chk("reply_byte", {24'd0, TxD_data}, 32'h4B);
      end
    end
`ifdef RXCMD_REPLY_EN
    chk("reply_cnt", pulses, 1);
`else
    chk("reply_cnt", pulses, 0);
`endif

    // randomized frames with corruption, gaps, busy and rare resets
    for (int f = 0; f < 200; f++) begin
      fr[0] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h23;
      pick  = ($urandom_range(0, 1) == 1) ? 8'h55 : 8'h4C;
      fr[1] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pick;
      fr[2] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(8'h30 + $urandom_range(0, 9));
      fr[3] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h0D;
      for (int b = 0; b < 4; b++) begin
        cycle(1'b1, fr[b], 1'($urandom_range(0, 1)), 1'b0);
        cnt = ($urandom_range(0, 14) == 0) ? $urandom_range(18, 24) : $urandom_range(0, 3);
        for (int g = 0; g < cnt; g++)
          cycle(1'b0, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));
      end
      cnt = $urandom_range(0, 30);
      for (int g = 0; g < cnt; g++)
        cycle(1'b0, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rx_cmd_decode.md
RX_CMD_DECODE -- requirements
Module: rx_cmd_decode

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50_000_000, clock cycles per unlock second.
REQ-002 SHALL have parameter FRAME_TIMEOUT, default 5_000_000, idle cycles allowed between bytes of a frame.
REQ-003 SHALL have port FPGA_CLK1_50  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port RxD_data  input  8  received byte, valid only while RxD_data_ready is high.
REQ-006 SHALL have port RxD_data_ready  input  1  one-cycle strobe per received byte.
REQ-007 SHALL have port TxD_busy  input  1  UART transmitter busy.
REQ-008 SHALL have port unlock_signal  output  1  door strike drive.
REQ-009 SHALL have port LED  output  8  ASCII argument of the last accepted 'L' command.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse per rejected or aborted frame.
REQ-011 SHALL have port TxD_data  output  8  reply byte to the UART transmitter.
REQ-012 SHALL have port TxD_start  output  1  one-cycle transmit request.

Function
REQ-013 SHALL accept frames of exactly four bytes: '#' (0x23), command, ASCII digit '0'-'9' (0x30-0x39), CR (0x0D).
REQ-014 SHALL recognise command 'U' (0x55) as unlock for the argument value in seconds and 'L' (0x4C) as set LED.
REQ-015 SHALL implement FSM states IDLE, GOT_START, GOT_CMD, GOT_ARG; transitions occur only on cycles with RxD_data_ready high.
REQ-016 SHALL ignore non-'#' bytes in IDLE (no frame_err).
REQ-017 SHALL move to GOT_START on '#' received in any state; frame_err SHALL pulse if the state was not IDLE.
REQ-018 SHALL return to IDLE with a frame_err pulse on an invalid command byte, non-digit argument, or non-CR terminator.
REQ-019 SHALL execute a frame on CR in GOT_ARG, with outputs updated on the cycle after the CR strobe (latency 1), and return to IDLE.
REQ-020 SHALL, on 'L' d, set LED to the argument byte (e.g., 0x35 for '5').
REQ-021 SHALL, on 'U' d with d>0, set unlock_signal high and load a 4-bit seconds counter with d and a tick counter with 0.
REQ-022 SHALL hold unlock_signal high for exactly d*TICKS_PER_SEC cycles; it SHALL fall when the seconds counter reaches 0.
REQ-023 SHALL, on 'U' '0', drive unlock_signal low on the next cycle (cancel).
REQ-024 SHALL, on a 'U' received while unlocked, reload the counters; the reload wins over a same-cycle expiry.
REQ-025 SHALL run a timeout counter in non-IDLE states, clear it on every strobe, and on reaching FRAME_TIMEOUT go to IDLE with a frame_err pulse.
REQ-026 SHALL let a strobe take priority over a timeout occurring in the same cycle.

Reset
REQ-027 SHALL, with reset high at a clock edge, enter IDLE and clear unlock_signal=0, LED=0x00, frame_err=0, TxD_data=0x00, TxD_start=0, all counters, and the reply-pending flag.
REQ-028 SHALL let reset mid-frame or mid-unlock discard the frame and drop unlock_signal on the next edge, with no frame_err.

Configuration
REQ-029 SHALL, with macro RXCMD_REPLY_EN defined, queue reply 'K' (0x4B) on each executed frame and 'E' (0x45) on each frame_err; a newer reply overwrites a pending one.
REQ-030 SHALL, with RXCMD_REPLY_EN defined, issue a pending reply when TxD_busy is low by driving TxD_data and pulsing TxD_start for one cycle, then clear the pending flag; TxD_data SHALL hold until the next reply.
REQ-031 SHALL, without RXCMD_REPLY_EN, tie TxD_start=0 and TxD_data=0x00; all other behaviour is unchanged.

Verification (TICKS_PER_SEC=10, FRAME_TIMEOUT=20)
REQ-032 SHALL cover: bytes 23 55 33 0D -> unlock_signal high from the cycle after CR for exactly 30 cycles, frame_err never pulses.
REQ-033 SHALL cover: 23 4C 37 0D -> LED=0x37 one cycle after CR; unlock_signal stays 0.
REQ-034 SHALL cover: 23 58 -> frame_err pulses one cycle after 0x58; following 23 4C 31 0D -> LED=0x31.
REQ-035 SHALL cover: 23 55, then 25 idle cycles -> frame_err pulse at cycle 20 after 0x55, FSM in IDLE; a later 55 byte is ignored.
REQ-036 SHALL cover: U '5' executed, 12 cycles later U '0' -> unlock_signal low next cycle; reset asserted mid-U '9' -> unlock_signal low next edge.
REQ-037 SHALL cover, with RXCMD_REPLY_EN and TxD_busy high for 8 cycles after a valid frame -> TxD_start pulses once with TxD_data=0x4B on the first cycle TxD_busy is low.
